merge_sort_feeder: RTL and testbench

//  Source side of the merge_sort_system input interface. Accepts a serial stream of signed

---
 rtl/merge_sort_feeder_if.sv | 26 ++
 rtl/merge_sort_feeder.sv | 138 +++++++++++++
 tb/tb_merge_sort_feeder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/merge_sort_feeder_if.sv
// Sample-in / beat-out bundle between the sample source, merge_sort_feeder and merge_sort_system.
// The feeder uses the slave view; the sample source and the sorter side use the master view.
interface merge_sort_feeder_if #(
    parameter int DATA_W = 8
);
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_ready;
    logic signed [DATA_W-1:0] In1;
    logic signed [DATA_W-1:0] In2;
    logic signed [DATA_W-1:0] In3;
    logic signed [DATA_W-1:0] In4;
    logic                     beat_valid;
    logic                     BlkIn;
    logic [1:0]               bank_full;

    modport master (
        output s_valid, s_data,
        input  s_ready, In1, In2, In3, In4, beat_valid, BlkIn, bank_full
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, In1, In2, In3, In4, beat_valid, BlkIn, bank_full
    );
endinterface

// File: rtl/merge_sort_feeder.sv
// Packs a serial sample stream into 32-sample blocks in a ping-pong buffer and replays each
// block as 8 frame-aligned beats of 4 lanes, paced by a minimum gap between BlkIn pulses.
//
// state | meaning
// IDLE  | no block on the lanes; waits for a frame start with a full send bank and gap expired
// EMIT  | lanes carry beat <slot> of the send bank; releases the bank after beat 7
module merge_sort_feeder #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int BEATS      = 8,
    parameter int GAP_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst,
    merge_sort_feeder_if.slave bus
);
    localparam int LANE_W = $clog2(LANES);
    localparam int SLOT_W = $clog2(BEATS);
    localparam int IDX_W  = SLOT_W + LANE_W;
    localparam int DEPTH  = LANES * BEATS;
    localparam int GAP_W  = (GAP_FRAMES > 2) ? $clog2(GAP_FRAMES) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_FRAMES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] mem [2][DEPTH];

    logic [IDX_W-1:0]  wr_idx, wr_idx_nxt;
    logic              fill, fill_nxt;
    logic              send, send_nxt;
    logic [1:0]        bank_full, bank_full_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt;
    logic [GAP_W-1:0]  gap, gap_nxt;

    logic signed [DATA_W-1:0] lane_q   [LANES];
    logic signed [DATA_W-1:0] lane_nxt [LANES];
    logic beat_valid_q, beat_valid_nxt;
    logic blk_q, blk_nxt;
    logic accept;

    assign bus.s_ready = rst && !bank_full[fill];
    assign accept      = bus.s_valid && bus.s_ready;

    // Emission decisions are taken on the edge into slot 0 using the post-edge bank/gap
    // view, so a block completed in slot 7 can start in the very next frame.
    always_comb begin
        state_nxt      = state;
        wr_idx_nxt     = wr_idx;
        fill_nxt       = fill;
        send_nxt       = send;
        bank_full_nxt  = bank_full;
        slot_nxt       = slot + 1'b1;
        gap_nxt        = gap;
        blk_nxt        = 1'b0;
        beat_valid_nxt = 1'b0;
        lane_nxt       = '{default: '0};

        if (accept) begin
            if (wr_idx == LAST_IDX) begin
                bank_full_nxt[fill] = 1'b1;
                wr_idx_nxt          = '0;
                fill_nxt            = ~fill;
            end else begin
                wr_idx_nxt = wr_idx + 1'b1;
            end
        end

        if (slot == LAST_SLOT) begin
            if (state == EMIT) begin
                bank_full_nxt[send] = 1'b0;
                send_nxt            = ~send;
                gap_nxt             = GAP_LOAD;
                blk_nxt             = 1'b1;
                state_nxt           = IDLE;
            end else if (gap != '0) begin
                gap_nxt = gap - 1'b1;
            end
            if (bank_full_nxt[send_nxt] && (gap_nxt == '0)) begin
                state_nxt = EMIT;
            end
        end

        if (state_nxt == EMIT) begin
            beat_valid_nxt = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                lane_nxt[l] = mem[send_nxt][{slot_nxt, LANE_W'(l)}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            wr_idx       <= '0;
            fill         <= 1'b0;
            send         <= 1'b0;
            bank_full    <= '0;
            slot         <= '0;
            gap          <= '0;
            blk_q        <= 1'b0;
            beat_valid_q <= 1'b0;
            lane_q       <= '{default: '0};
        end else begin
            state        <= state_nxt;
            wr_idx       <= wr_idx_nxt;
            fill         <= fill_nxt;
            send         <= send_nxt;
            bank_full    <= bank_full_nxt;
            slot         <= slot_nxt;
            gap          <= gap_nxt;
            blk_q        <= blk_nxt;
            beat_valid_q <= beat_valid_nxt;
            lane_q       <= lane_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[fill][wr_idx] <= bus.s_data;
        end
    end

    assign bus.In1        = lane_q[0];
    assign bus.In2        = lane_q[1];
    assign bus.In3        = lane_q[2];
    assign bus.In4        = lane_q[3];
    assign bus.beat_valid = beat_valid_q;
    assign bus.BlkIn      = blk_q;
    assign bus.bank_full  = bank_full;
endmodule

// File: tb/tb_merge_sort_feeder.sv
// Self-checking bench for merge_sort_feeder: queue-based block model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_merge_sort_feeder;
    logic clk;
    logic rst;

    merge_sort_feeder_if #(.DATA_W(8)) bus ();

    merge_sort_feeder #(
        .DATA_W(8), .LANES(4), .BEATS(8), .GAP_FRAMES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    int t         = 0;
    bit rst_seen  = 0;
    bit emitting  = 0;
    int start     = 0;
    int next_ok   = 0;
    int blk_due   = -1;
    int nblk      = 0;
    logic signed [7:0] store_q[$];
    logic signed [7:0] part_q[$];
    int bank_q[$];
    int blk_times[$];

    task automatic chk(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d (t=%0d)", name, act, want, t);
    endtask

    // Reference model: a block occupies a bank from its 32nd accept until its 8th beat is
    // out; it starts at a frame boundary once complete and 32 cycles after the previous start.
    always @(negedge clk) begin
        int e_ready, e_bv, e_bf, e_blk;
        int e_in [4];
        if (!rst) begin
            chk("rst_s_ready", int'(bus.s_ready), 0);
            if (rst_seen) begin
                chk("rst_beat_valid", int'(bus.beat_valid), 0);
                chk("rst_blkin", int'(bus.BlkIn), 0);
                chk("rst_bank_full", int'(bus.bank_full), 0);
                chk("rst_in1", int'(bus.In1), 0);
                chk("rst_in4", int'(bus.In4), 0);
            end
            store_q.delete(); part_q.delete(); bank_q.delete();
            nblk = 0; t = 0; emitting = 0; next_ok = 0; blk_due = -1;
            rst_seen = 1;
        end else begin
            rst_seen = 0;
            if ((t % 8 == 0) && !emitting && (bank_q.size() > 0) && (t >= next_ok)) begin
                emitting = 1;
                start    = t;
                next_ok  = t + 32;
            end
            e_ready = (bank_q.size() < 2) ? 1 : 0;
            e_bv    = emitting ? 1 : 0;
            e_blk   = (t == blk_due) ? 1 : 0;
            e_bf    = 0;
            foreach (bank_q[i]) e_bf = e_bf | (1 << bank_q[i]);
            for (int l = 0; l < 4; l++)
                e_in[l] = emitting ? int'(store_q[4 * (t - start) + l]) : 0;

            chk("s_ready", int'(bus.s_ready), e_ready);
            chk("beat_valid", int'(bus.beat_valid), e_bv);
            chk("blkin", int'(bus.BlkIn), e_blk);
            chk("bank_full", int'(bus.bank_full), e_bf);
            chk("in1", int'(bus.In1), e_in[0]);
            chk("in2", int'(bus.In2), e_in[1]);
            chk("in3", int'(bus.In3), e_in[2]);
            chk("in4", int'(bus.In4), e_in[3]);

            if (bus.BlkIn) blk_times.push_back(t);

            if (bus.s_valid && (e_ready == 1)) begin
                part_q.push_back(bus.s_data);
                if (part_q.size() == 32) begin
                    foreach (part_q[i]) store_q.push_back(part_q[i]);
                    bank_q.push_back(nblk % 2);
                    nblk++;
                    part_q.delete();
                end
            end
            if (emitting && (t == start + 7)) begin
                for (int i = 0; i < 32; i++) void'(store_q.pop_front());
                void'(bank_q.pop_front());
                emitting = 0;
                blk_due  = t + 1;
            end
            t++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles, input logic valid);
        tick();
        rst         = 1'b0;
        bus.s_valid = valid;
        bus.s_data  = 8'sh5A;
        repeat (cycles) tick();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        blk_times.delete();
    endtask

    logic signed [7:0] pat [4];
    logic signed [7:0] data3 [96];

    initial begin
        int k, cyc, rst_at, pct;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        pat[0] = 8'sh80; pat[1] = 8'sh7F; pat[2] = 8'shFF; pat[3] = 8'sh00;

        // 1: reset with s_valid high stores nothing
        do_reset(3, 1'b1);
        @(negedge clk);
        chk("t1_bank_full", int'(bus.bank_full), 0);
        chk("t1_beat_valid", int'(bus.beat_valid), 0);

        // 2: samples 0..31 back-to-back
        do_reset(3, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 8'(i); tick();
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("t2_b0_in1", int'(bus.In1), 0);
        chk("t2_b0_in2", int'(bus.In2), 1);
        chk("t2_b0_in3", int'(bus.In3), 2);
        chk("t2_b0_in4", int'(bus.In4), 3);
        chk("t2_b0_valid", int'(bus.beat_valid), 1);
        repeat (7) @(negedge clk);
        chk("t2_b7_in1", int'(bus.In1), 28);
        chk("t2_b7_in4", int'(bus.In4), 31);
        @(negedge clk);
        chk("t2_blkin", int'(bus.BlkIn), 1);
        chk("t2_bank_full", int'(bus.bank_full), 0);
        chk("t2_valid_after", int'(bus.beat_valid), 0);
        @(negedge clk);
        chk("t2_blkin_once", int'(bus.BlkIn), 0);

        // 3: 96 samples continuous
        for (int i = 0; i < 96; i++) data3[i] = 8'($urandom);
        do_reset(3, 1'b0);
        k = 0; cyc = 0;
        while ((k < 96) && (cyc < 400)) begin
            bus.s_valid = 1'b1; bus.s_data = data3[k];
            if (bus.s_ready) k++;
            tick(); cyc++;
        end
        chk("t3_accepts", k, 96);
        bus.s_valid = 1'b0;
        repeat (24) tick();
        chk("t3_blkin_count", blk_times.size(), 3);
        if (blk_times.size() == 3) begin
            chk("t3_first_blkin", blk_times[0], 40);
            chk("t3_spacing_a", blk_times[1] - blk_times[0], 32);
            chk("t3_spacing_b", blk_times[2] - blk_times[1], 32);
        end

        // 4: extreme signed values; 5: reset at beat 4
        do_reset(3, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bus.s_valid = 1'b1; bus.s_data = pat[i % 4]; tick();
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("t4_in1", int'(bus.In1), -128);
        chk("t4_in2", int'(bus.In2), 127);
        chk("t4_in3", int'(bus.In3), -1);
        chk("t4_in4", int'(bus.In4), 0);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_beat_valid", int'(bus.beat_valid), 0);
        chk("t5_in1", int'(bus.In1), 0);
        chk("t5_bank_full", int'(bus.bank_full), 0);
        chk("t5_blkin", int'(bus.BlkIn), 0);
        tick();
        rst = 1'b1;
        blk_times.delete();
        repeat (48) tick();
        chk("t5_no_blkin", blk_times.size(), 0);

        // 6: one sample every other cycle
        do_reset(3, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 8'(i); tick();
            bus.s_valid = 1'b0; tick();
        end
        @(negedge clk);
        chk("t6_b0_in1", int'(bus.In1), 0);
        chk("t6_b0_in4", int'(bus.In4), 3);
        chk("t6_b0_valid", int'(bus.beat_valid), 1);
        repeat (7) @(negedge clk);
        chk("t6_b7_in3", int'(bus.In3), 30);

        // random traffic, one run with a mid-stream reset
        for (int r = 0; r < 3; r++) begin
            do_reset(2, 1'b0);
            rst_at = (r == 1) ? int'($urandom_range(100, 300)) : -10;
            pct    = (r == 0) ? 100 : ((r == 1) ? 70 : 40);
            for (int c = 0; c < 500; c++) begin
                bus.s_valid = ($urandom_range(0, 99) < pct);
                bus.s_data  = 8'($urandom);
                if (c == rst_at) rst = 1'b0;
                else if (c == rst_at + 2) rst = 1'b1;
                tick();
            end
        end
        bus.s_valid = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got %0d passed of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
